fb_port_arbiter: RTL

Arbitrates the framebuffer's single write/read port pair (8-bit indexed RGB plane and 24-bit palette) between two requesters: requester 0 is the SPI GPU command path, requester 1 is a fill/blit engine. Requesters are granted round-robin, one access per clock. Palette writes are optionally held until vertical blanking so that palette changes never tear a visible frame. The block sits between the requesters and the framebuffer, and drives the framebuffer's rgb/palette port signals in the clk_pixel domain.

---
 rtl/fb_port_arbiter.sv | 128 ++++++++++++
 1 files changed

// File: rtl/fb_port_arbiter.sv
// Round-robin arbiter between the SPI GPU path (requester 0) and the fill/blit
// engine (requester 1) for the framebuffer RGB plane and palette ports.
module fb_port_arbiter #(
    parameter int RGB_ADDR_W = 17,
    parameter int PAL_ADDR_W = 8,
    parameter int PAL_DEFER  = 1
) (
    input  logic                    clk_pixel,
    input  logic                    reset,

    input  logic [1:0]              req_valid,
    output logic [1:0]              req_ready,
    input  logic [1:0]              req_sel,
    input  logic [1:0]              req_we,
    input  logic [2*RGB_ADDR_W-1:0] req_addr,
    input  logic [47:0]             req_wdata,

    output logic [1:0]              rsp_valid,
    output logic [23:0]             rsp_data,

    input  logic                    vblank,

    output logic [RGB_ADDR_W-1:0]   framebuffer_rgb_addr,
    output logic [7:0]              framebuffer_rgb_in,
    output logic                    framebuffer_wren_rgb,
    input  logic [7:0]              framebuffer_rgb_out,
    output logic [PAL_ADDR_W-1:0]   framebuffer_palette_addr,
    output logic [23:0]             framebuffer_palette_in,
    output logic                    framebuffer_wren_palette,
    input  logic [23:0]             framebuffer_palette_out
);

    typedef struct packed {
        logic valid;
        logic owner;
        logic sel;
    } read_tag_t;

    logic [1:0]            eligible;
    logic [1:0]            grant;
    logic                  last;
    logic                  transfer;
    logic                  gidx;
    logic                  g_sel;
    logic                  g_we;
    logic [RGB_ADDR_W-1:0] g_addr;
    logic [23:0]           g_wdata;
    read_tag_t             tag1;
    read_tag_t             tag2;

    // Palette writes outside vblank are held back so a visible frame never tears.
    always_comb begin
        eligible = 2'b00;
        for (int i = 0; i < 2; i++) begin
            eligible[i] = req_valid[i] &&
                          !((PAL_DEFER != 0) && req_sel[i] && req_we[i] && !vblank);
        end
    end

    always_comb begin
        grant = 2'b00;
        if (reset) begin
            grant = 2'b00;
        end else if (eligible == 2'b11) begin
            grant = last ? 2'b01 : 2'b10;
        end else begin
            grant = eligible;
        end
    end

    assign req_ready = grant;
    assign transfer  = |(grant & req_valid);
    assign gidx      = grant[1];
    assign g_sel     = gidx ? req_sel[1] : req_sel[0];
    assign g_we      = gidx ? req_we[1] : req_we[0];
    assign g_addr    = gidx ? req_addr[2*RGB_ADDR_W-1:RGB_ADDR_W] : req_addr[RGB_ADDR_W-1:0];
    assign g_wdata   = gidx ? req_wdata[47:24] : req_wdata[23:0];

    always_ff @(posedge clk_pixel) begin
        if (reset) begin
            last                     <= 1'b1;
            framebuffer_rgb_addr     <= '0;
            framebuffer_rgb_in       <= '0;
            framebuffer_wren_rgb     <= 1'b0;
            framebuffer_palette_addr <= '0;
            framebuffer_palette_in   <= '0;
            framebuffer_wren_palette <= 1'b0;
        end else begin
            framebuffer_wren_rgb     <= 1'b0;
            framebuffer_wren_palette <= 1'b0;
            if (transfer) begin
                last <= gidx;
                if (g_sel) begin
                    framebuffer_palette_addr <= g_addr[PAL_ADDR_W-1:0];
                    framebuffer_palette_in   <= g_wdata;
                    framebuffer_wren_palette <= g_we;
                end else begin
                    framebuffer_rgb_addr     <= g_addr;
                    framebuffer_rgb_in       <= g_wdata[7:0];
                    framebuffer_wren_rgb     <= g_we;
                end
            end
        end
    end

    // Read tags track the framebuffer's one-cycle read latency so responses
    // land on the owner in grant order.
    always_ff @(posedge clk_pixel) begin
        if (reset) begin
            tag1      <= '0;
            tag2      <= '0;
            rsp_valid <= 2'b00;
            rsp_data  <= '0;
        end else begin
            tag1.valid <= transfer && !g_we;
            tag1.owner <= gidx;
            tag1.sel   <= g_sel;
            tag2       <= tag1;
            rsp_valid  <= 2'b00;
            if (tag2.valid) begin
                rsp_valid <= tag2.owner ? 2'b10 : 2'b01;
                rsp_data  <= tag2.sel ? framebuffer_palette_out
                                      : {16'b0, framebuffer_rgb_out};
            end
        end
    end

endmodule
